port_priority_scheduler: RTL and testbench

//  Upstream of port_prioritizer: generates its 3-bit port_priority select each cycle.

---
 rtl/port_priority_scheduler.sv | 110 +++++++++++
 tb/tb_port_priority_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/port_priority_scheduler.sv
// Round-robin priority select generator for port_prioritizer.
// Starving ports are promoted ahead of the rotation order.
module port_priority_scheduler #(
    parameter int WAIT_W       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       port1_valid,
    input  logic       port2_valid,
    input  logic       port3_valid,
    input  logic       port1_served,
    input  logic       port2_served,
    input  logic       port3_served,
    output logic [2:0] port_priority,
    output logic [2:0] starve_flag
);

    localparam logic [WAIT_W-1:0] CNT_MAX = '1;
    localparam logic [WAIT_W-1:0] LIMIT   = WAIT_W'(STARVE_LIMIT);

    logic [2:0]        valid;
    logic [2:0]        served;
    logic [WAIT_W-1:0] wait_cnt [3];
    logic [1:0]        rr_ptr;
    logic [1:0]        base [3];
    logic [1:0]        ord  [3];
    logic [1:0]        n;
    logic [2:0]        next_code;

    assign valid  = {port3_valid, port2_valid, port1_valid};
    assign served = {port3_served, port2_served, port1_served};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            starve_flag[i] = (wait_cnt[i] >= LIMIT);
        end
    end

    // Ports are 0-based here: port N is index N-1.
    always_comb begin
        base[0] = 2'd0;
        base[1] = 2'd1;
        base[2] = 2'd2;
        unique case (rr_ptr)
            2'd1: begin
                base[0] = 2'd1;
                base[1] = 2'd2;
                base[2] = 2'd0;
            end
            2'd2: begin
                base[0] = 2'd2;
                base[1] = 2'd0;
                base[2] = 2'd1;
            end
            default: ;
        endcase
    end

    // Stable partition: starved ports first, each group in base order.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ord[i] = 2'd0;
        end
        n = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (starve_flag[base[i]]) begin
                ord[n] = base[i];
                n      = n + 2'd1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!starve_flag[base[i]]) begin
                ord[n] = base[i];
                n      = n + 2'd1;
            end
        end
    end

    // Code = 2*first + (second outranks third by port number).
    assign next_code = {ord[0], ord[1] > ord[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_priority <= 3'd0;
            rr_ptr        <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                wait_cnt[i] <= '0;
            end
        end else if (en) begin
            port_priority <= next_code;
            for (int i = 0; i < 3; i++) begin
                if (served[i]) begin
                    wait_cnt[i] <= '0;
                end else if (valid[i]) begin
                    if (wait_cnt[i] != CNT_MAX) begin
                        wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
            if (|served) begin
                rr_ptr <= (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_port_priority_scheduler.sv
// Scoreboard bench for port_priority_scheduler.
// Reference model works on port numbers and orderings, not encodings.
module tb_port_priority_scheduler;

    localparam int WAIT_W = 4;
    localparam int LIM    = 8;
    localparam int WMAX   = (1 << WAIT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] v;
    logic [2:0] s;
    logic [2:0] port_priority;
    logic [2:0] starve_flag;

    typedef struct {
        logic [2:0] pp;
        logic [2:0] sf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   w[3];
    int   rr;
    logic [2:0] mpp;

    always #5 clk = ~clk;

    port_priority_scheduler #(.WAIT_W(WAIT_W), .STARVE_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .port1_valid  (v[0]),
        .port2_valid  (v[1]),
        .port3_valid  (v[2]),
        .port1_served (s[0]),
        .port2_served (s[1]),
        .port3_served (s[2]),
        .port_priority(port_priority),
        .starve_flag  (starve_flag)
    );

    // Priority order as a list of port numbers, mapped to its code
    // by position in the enumerated permutation table.
    function automatic logic [2:0] model_code(input logic [2:0] st, input int r);
        int perms[6] = '{123, 132, 213, 231, 312, 321};
        int base[3];
        int ord[$];
        int val;
        for (int i = 0; i < 3; i++) base[i] = (r + i) % 3 + 1;
        for (int i = 0; i < 3; i++) if (st[base[i]-1]) ord.push_back(base[i]);
        for (int i = 0; i < 3; i++) if (!st[base[i]-1]) ord.push_back(base[i]);
        val = ord[0] * 100 + ord[1] * 10 + ord[2];
        for (int i = 0; i < 6; i++) if (perms[i] == val) return 3'(i);
        return 3'd7;
    endfunction

    function automatic logic [2:0] model_flags();
        logic [2:0] f;
        for (int i = 0; i < 3; i++) f[i] = (w[i] >= LIM);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) w[i] = 0;
        rr  = 0;
        mpp = 3'd0;
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, push expectation.
    task automatic cycle(input logic e, input logic [2:0] vv, input logic [2:0] ss);
        exp_t x;
        @(negedge clk);
        en = e;
        v  = vv;
        s  = ss;
        @(posedge clk);
        if (e) begin
            mpp = model_code(model_flags(), rr);
            for (int i = 0; i < 3; i++) begin
                if (ss[i])      w[i] = 0;
                else if (vv[i]) w[i] = (w[i] < WMAX) ? w[i] + 1 : WMAX;
                else            w[i] = 0;
            end
            if (ss != 3'b000) rr = (rr + 1) % 3;
        end
        x.pp = mpp;
        x.sf = model_flags();
        q.push_back(x);
        #1;
    endtask

    // Reset asserted away from clock edges, checked before any edge passes.
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'($urandom);
        v     = 3'($urandom);
        s     = 3'($urandom);
        #1;
        chk({name, "_pp"}, port_priority, 3'd0);
        chk({name, "_sf"}, starve_flag, 3'd0);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            v = 3'($urandom);
            s = 3'($urandom);
        end
        #2;
        rst_n = 1'b1;
        en    = 1'b0;
        v     = 3'b000;
        s     = 3'b000;
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk("sb_pp", port_priority, x.pp);
            chk("sb_sf", starve_flag, x.sf);
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        v     = 3'b111;
        s     = 3'b101;
        model_reset();
        #1;
        chk("rst0_pp", port_priority, 3'd0);
        chk("rst0_sf", starve_flag, 3'd0);
        #1;
        v = 3'b010;
        s = 3'b011;
        #1;
        chk("rst0b_pp", port_priority, 3'd0);
        do_reset("rst1");

        // Rotation with one port-1 serve every third cycle.
        cycle(1, 3'b111, 3'b001);
        cycle(1, 3'b111, 3'b000);
        chk("rot_231", port_priority, 3'd3);
        cycle(1, 3'b111, 3'b000);
        cycle(1, 3'b111, 3'b001);
        cycle(1, 3'b111, 3'b000);
        chk("rot_312", port_priority, 3'd4);
        cycle(1, 3'b111, 3'b000);
        cycle(1, 3'b111, 3'b001);
        cycle(1, 3'b111, 3'b000);
        chk("rot_123", port_priority, 3'd0);

        // Port 3 alone starves, then saturates without wrapping.
        do_reset("rst2");
        for (int i = 1; i <= 20; i++) begin
            cycle(1, 3'b100, 3'b000);
            if (i == 7) chk("st3_e7_sf", starve_flag, 3'b000);
            if (i == 8) chk("st3_e8_sf", starve_flag, 3'b100);
            if (i == 8) chk("st3_e8_pp", port_priority, 3'd0);
            if (i == 9) chk("st3_e9_pp", port_priority, 3'd4);
        end
        chk("sat_sf", starve_flag, 3'b100);
        chk("sat_pp", port_priority, 3'd4);

        // Ports 2 and 3 starved; then port 2 served twice.
        do_reset("rst3");
        repeat (9) cycle(1, 3'b110, 3'b000);
        chk("st23_pp", port_priority, 3'd3);
        cycle(1, 3'b110, 3'b010);
        cycle(1, 3'b110, 3'b010);
        chk("st3_rr1_pp", port_priority, 3'd5);
        cycle(1, 3'b110, 3'b000);
        chk("st3_rr2_pp", port_priority, 3'd4);

        // Served wins over valid in the same cycle.
        do_reset("rst4");
        repeat (9) cycle(1, 3'b010, 3'b000);
        chk("w2_9_sf", starve_flag, 3'b010);
        cycle(1, 3'b010, 3'b010);
        chk("sv_sf", starve_flag, 3'b000);
        chk("sv_pp", port_priority, 3'd2);
        cycle(1, 3'b000, 3'b000);
        chk("sv_rr_pp", port_priority, 3'd3);

        // Enable low freezes everything; served pulses are lost.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 3'($urandom), 3'($urandom));
            chk("hold_pp", port_priority, 3'd3);
            chk("hold_sf", starve_flag, 3'b000);
        end
        cycle(1, 3'b000, 3'b000);
        chk("hold_after_pp", port_priority, 3'd3);
        do_reset("rst5");
        cycle(1, 3'b000, 3'b000);
        chk("post_rst_pp", port_priority, 3'd0);

        // Random traffic with sparse serves so starvation occurs.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] vv;
            logic [2:0] ss;
            for (int p = 0; p < 3; p++) begin
                vv[p] = ($urandom_range(0, 9) < 8);
                ss[p] = ($urandom_range(0, 9) == 0);
            end
            cycle($urandom_range(0, 9) < 9, vv, ss);
            if (i == 700) do_reset("rst_rand");
        end

        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
